lt_readout_ctrl: RTL and testbench

LT_READOUT_CTRL -- requirements
Module: lt_readout_ctrl

---
 rtl/lt_readout_ctrl.sv | 147 ++++++++++++++
 tb/tb_lt_readout_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lt_readout_ctrl.sv
// Logic-thief capture readout: walks BRAM capture entries on software request
// and holds one entry at a time for 32-bit slice readback.
module lt_readout_ctrl #(
    parameter int unsigned LOGTHIEF_DATA_WIDTH = 192,
    parameter int unsigned LOGTHIEF_LOG2_DEEP  = 8,
    parameter int unsigned STATUS_LSB          = 171,
    parameter int unsigned RD_LATENCY          = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           sw_req_i,
    input  logic [LOGTHIEF_LOG2_DEEP-1:0]  sw_addr_i,
    input  logic                           sw_burst_i,
    input  logic                           sw_ack_i,
    input  logic                           sw_abort_i,
    input  logic [2:0]                     rd_word_sel_i,
    input  logic [LOGTHIEF_DATA_WIDTH-1:0] lt_data_i,
    output logic [31:0]                    lt_addr_o,
    output logic [31:0]                    rd_word_o,
    output logic [LOGTHIEF_LOG2_DEEP-1:0]  entry_o,
    output logic                           busy_o,
    output logic                           valid_o,
    output logic                           done_o,
    output logic                           capture_full_o
);

    localparam int unsigned AW    = LOGTHIEF_LOG2_DEEP;
    localparam int unsigned DW    = LOGTHIEF_DATA_WIDTH;
    localparam int unsigned CNT_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);
    localparam int unsigned EXT_W = (DW > 192) ? DW : 192;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [AW-1:0]     entry_q, entry_d;
    logic [DW-1:0]     hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              burst_q, burst_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [EXT_W-1:0]  hold_ext;

    // Next-state and register-input computation
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        entry_d = entry_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        valid_d = valid_q;
        done_d  = done_q;

        if (sw_abort_i) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sw_req_i) begin
                        addr_d  = sw_addr_i;
                        burst_d = sw_burst_i;
                        done_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Address has been stable RD_LATENCY cycles; data is valid now
                    if (cnt_q == CNT_W'(RD_LATENCY)) begin
                        hold_d  = lt_data_i;
                        entry_d = addr_q;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (sw_ack_i && valid_q) begin
                        valid_d = 1'b0;
                        if (burst_q && (addr_q != {AW{1'b1}})) begin
                            addr_d  = addr_q + AW'(1);
                            cnt_d   = '0;
                            state_d = ST_WAIT;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            entry_q <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            burst_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            entry_q <= entry_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Zero-extend so slices past the entry width read as 0
    assign hold_ext = EXT_W'(hold_q);

    always_comb begin
        rd_word_o = '0;
        for (int unsigned n = 0; n < 6; n++) begin
            if (rd_word_sel_i == 3'(n)) rd_word_o = hold_ext[32*n +: 32];
        end
    end

    assign capture_full_o = &hold_q[DW-1:STATUS_LSB];
    assign lt_addr_o      = 32'(addr_q);
    assign entry_o        = entry_q;
    assign busy_o         = busy_q;
    assign valid_o        = valid_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_lt_readout_ctrl.sv
// Randomized bench for lt_readout_ctrl against a BRAM model and an entry-sequence reference.
module tb_lt_readout_ctrl;

    localparam int unsigned LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sw_req, sw_burst, sw_ack, sw_abort;
    logic [7:0]   sw_addr;
    logic [2:0]   sel;
    logic [191:0] lt_data;
    logic [31:0]  lt_addr, rd_word;
    logic [7:0]   entry;
    logic         busy, valid, done, cfull;

    logic [191:0] mem [256];
    logic [7:0]   a1, a2;
    int           n_chk  = 0;
    int           n_pass = 0;

    lt_readout_ctrl dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .sw_req_i       (sw_req),
        .sw_addr_i      (sw_addr),
        .sw_burst_i     (sw_burst),
        .sw_ack_i       (sw_ack),
        .sw_abort_i     (sw_abort),
        .rd_word_sel_i  (sel),
        .lt_data_i      (lt_data),
        .lt_addr_o      (lt_addr),
        .rd_word_o      (rd_word),
        .entry_o        (entry),
        .busy_o         (busy),
        .valid_o        (valid),
        .done_o         (done),
        .capture_full_o (cfull)
    );

    always #10 clk = ~clk;

    // BRAM model: data for an address appears LAT cycles after the address changes
    always @(posedge clk) begin
        a1 <= lt_addr[7:0];
        a2 <= a1;
    end
    assign lt_data = mem[a2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] ref_word(input int e, input int s);
        logic [191:0] w;
        w = mem[e];
        return (s < 6) ? w[32*s +: 32] : 32'h0;
    endfunction

    function automatic logic ref_full(input int e);
        logic [191:0] w;
        w = mem[e];
        return &w[191:171];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_req(input int addr, input bit burst);
        sw_req = 1'b1; sw_addr = 8'(addr); sw_burst = burst;
        step();
        sw_req = 1'b0; sw_addr = 8'($urandom); sw_burst = 1'($urandom);
        chk("req_done_clr", done, 1'b0);
        chk("req_valid", valid, 1'b0);
    endtask

    task automatic wait_valid(input bit ack_noise);
        int n = 0;
        while (!valid && n < 20) begin
            sw_ack = ack_noise && (n == 0);
            step();
            sw_ack = 1'b0;
            n++;
        end
        chk("latency", 64'(n), 64'(LAT + 1));
    endtask

    task automatic check_entry(input int e);
        chk("entry", entry, 64'(e));
        chk("full", cfull, ref_full(e));
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            chk($sformatf("word%0d", s), rd_word, ref_word(e, s));
        end
    endtask

    task automatic ack();
        sw_ack = 1'b1;
        step();
        sw_ack = 1'b0;
    endtask

    // Reference: a request walks addr..last (last = 255 in burst), one held entry per ack
    task automatic run_seq(input int addr, input bit burst, input bit noise);
        int last;
        int gap;
        last = burst ? 255 : addr;
        do_req(addr, burst);
        for (int e = addr; e <= last; e++) begin
            chk("lt_addr", lt_addr, 64'(e));
            chk("busy", busy, 1'b1);
            wait_valid(noise);
            check_entry(e);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                sw_req = 1'b1; sw_addr = 8'($urandom); sw_burst = 1'($urandom);
                step();
                sw_req = 1'b0;
                chk("hold_valid", valid, 1'b1);
                chk("hold_addr", lt_addr, 64'(e));
            end
            ack();
        end
        chk("end_done", done, 1'b1);
        chk("end_busy", busy, 1'b0);
        chk("end_valid", valid, 1'b0);
        chk("end_addr", lt_addr, 64'(last));
        step();
        chk("done_hold", done, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) mem[i][191:171] = '1;
        end
        mem[5][7:0]      = 8'hA5;
        mem[8'h10][191:171] = '1;
        mem[8'h11][191:171] = '1;
        mem[8'h11][171 + $urandom_range(0, 20)] = 1'b0;
        mem[8'h20][191:171] = '1;

        rst_n = 1'b0; sw_req = 0; sw_burst = 0; sw_ack = 0; sw_abort = 0;
        sw_addr = 0; sel = 0;
        #35;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", lt_addr, 0);
        chk("rst_entry", entry, 0);
        chk("rst_full", cfull, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_seq(8'h05, 1'b0, 1'b0);
        run_seq(8'hFD, 1'b1, 1'b0);
        run_seq(8'h10, 1'b0, 1'b0);
        run_seq(8'h11, 1'b0, 1'b1);

        // Abort clears done and keeps the held entry
        sw_abort = 1'b1; step(); sw_abort = 1'b0;
        chk("abort_done", done, 1'b0);
        chk("abort_entry", entry, 8'h11);

        // Abort wins over a simultaneous ack in HOLD
        do_req(8'h20, 1'b1);
        wait_valid(1'b0);
        check_entry(8'h20);
        sw_abort = 1'b1; sw_ack = 1'b1;
        step();
        sw_abort = 1'b0; sw_ack = 1'b0;
        chk("abrt_busy", busy, 1'b0);
        chk("abrt_valid", valid, 1'b0);
        chk("abrt_done", done, 1'b0);
        chk("abrt_addr", lt_addr, 8'h20);
        chk("abrt_entry", entry, 8'h20);
        chk("abrt_word", rd_word, ref_word(8'h20, 7));
        sel = 3'd0; #1;
        chk("abrt_word0", rd_word, ref_word(8'h20, 0));

        // Abort wins over a simultaneous request in IDLE
        sw_abort = 1'b1; sw_req = 1'b1; sw_addr = 8'h33;
        step();
        sw_abort = 1'b0; sw_req = 1'b0;
        chk("abrq_busy", busy, 1'b0);
        chk("abrq_addr", lt_addr, 8'h20);

        // Abort during WAIT
        do_req(8'h21, 1'b0);
        sw_abort = 1'b1; step(); sw_abort = 1'b0;
        chk("abw_busy", busy, 1'b0);
        chk("abw_valid", valid, 1'b0);
        repeat (4) step();
        chk("abw_idle", busy, 1'b0);
        chk("abw_entry", entry, 8'h20);

        for (int t = 0; t < 6; t++) begin
            bit b;
            int a;
            b = 1'($urandom);
            a = b ? int'($urandom_range(248, 255)) : int'($urandom_range(0, 255));
            run_seq(a, b, 1'($urandom));
        end

        // Refresh a full-status entry so the async reset has nonzero outputs to clear
        run_seq(8'h20, 1'b0, 1'b0);
        do_req(8'h40, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_valid", valid, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_addr", lt_addr, 0);
        chk("arst_entry", entry, 0);
        chk("arst_full", cfull, 1'b0);
        chk("arst_word", rd_word, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step();
        chk("post_busy", busy, 1'b0);
        chk("post_valid", valid, 1'b0);
        chk("post_done", done, 1'b0);
        chk("post_addr", lt_addr, 0);

        run_seq(8'h41, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
